ifetch_buffer: RTL

- Instruction fetch stage directly downstream of the program counter.
- Takes the current instruction pointer and issues one read per cycle to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, each tagged with its address, in a small FIFO and hands them to the decoder over a valid/ready handshake.
- Back-pressures the PC with a stall output and discards all buffered and in-flight work on a flush caused by a taken jump or branch.

---
 rtl/ifetch_buffer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ifetch_buffer.sv
// ifetch_buffer -- instruction fetch stage between the PC and the decoder.
//
// Issues one read per cycle to a synchronous instruction memory (1-cycle
// read latency), captures each returned word with its address in a small
// FIFO and hands the head entry to the decoder. The PC is back-pressured
// through pc_stall_o, and a flush squashes all buffered and in-flight work.
//
// Optional feature: define IFETCH_BYPASS_EN to present a returning word in
// the same cycle it arrives when the FIFO is empty (1-cycle request-to-valid
// latency instead of 2).
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous, active-high reset
//   pc_addr_i      current instruction pointer
//   flush_i        taken jump/branch, squash everything
//   pc_stall_o     PC must hold its value this cycle
//   imem_req_o     instruction memory read strobe
//   imem_addr_o    instruction memory read address
//   imem_rdata_i   read data, valid the cycle after the request
//   instr_valid_o  instr_o / instr_pc_o valid
//   instr_ready_i  decoder accepts the head entry
//   instr_o        instruction word
//   instr_pc_o     address of instr_o
//
// Handshake: an entry transfers in a cycle where instr_valid_o and
// instr_ready_i are both high. While instr_valid_o is high and
// instr_ready_i is low, instr_o and instr_pc_o hold steady until the entry
// is accepted or a flush discards it. instr_ready_i is ignored while
// instr_valid_o is low.
module ifetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] pc_addr_i,
    input  logic          flush_i,
    output logic          pc_stall_o,
    output logic          imem_req_o,
    output logic [AW-1:0] imem_addr_o,
    input  logic [DW-1:0] imem_rdata_i,
    output logic          instr_valid_o,
    input  logic          instr_ready_i,
    output logic [DW-1:0] instr_o,
    output logic [AW-1:0] instr_pc_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] pc_mem  [DEPTH];
    logic [DW-1:0] ins_mem [DEPTH];

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          inflight_r;
    logic [AW-1:0] inflight_pc_r;

    logic          fifo_valid;
    logic [CW:0]   credits;
    logic          stall;
    logic          byp_active;
    logic          byp_take;
    logic          push;
    logic          pop;

    assign fifo_valid = (count_r != '0);

    // Credit check counts the read already in flight, so a returning word
    // always finds a free slot.
    assign credits = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
    assign stall   = (credits >= (CW+1)'(DEPTH));

`ifdef IFETCH_BYPASS_EN
    assign byp_active = ~fifo_valid & inflight_r & ~flush_i;
    assign byp_take   = byp_active & instr_ready_i;
`else
    assign byp_active = 1'b0;
    assign byp_take   = 1'b0;
`endif

    assign push = inflight_r & ~flush_i & ~byp_take;
    assign pop  = fifo_valid & instr_ready_i & ~flush_i;

    assign pc_stall_o    = stall & ~flush_i;
    assign imem_req_o    = ~stall & ~flush_i & ~rst_i;
    assign imem_addr_o   = pc_addr_i;

    // Outputs are forced to zero when nothing is presented, so unreset
    // storage never leaks onto the decoder interface.
    assign instr_valid_o = fifo_valid | byp_active;

    always_comb begin
        instr_o    = '0;
        instr_pc_o = '0;
        if (fifo_valid) begin
            instr_o    = ins_mem[rd_ptr_r];
            instr_pc_o = pc_mem[rd_ptr_r];
        end else if (byp_active) begin
            instr_o    = imem_rdata_i;
            instr_pc_o = inflight_pc_r;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_r]  <= inflight_pc_r;
            ins_mem[wr_ptr_r] <= imem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else if (flush_i) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= imem_req_o;
            if (imem_req_o) begin
                inflight_pc_r <= pc_addr_i;
            end
            if (push) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
